// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts one cipher key and streams round keys
// 0..NUM_ROUNDS over a valid/ready handshake, one key per accepted transfer.
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] round_key,
    output logic         round_key_valid,
    input  logic         round_key_ready,
    output logic [3:0]   round_idx,
    output logic         last
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [7:0]   rcon;
    logic         load_key;
    logic         advance;
    logic         finish;
    logic [127:0] next_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next round key derived from the registered current key.
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, t_word;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0     = round_key[127:96];
        w1     = round_key[95:64];
        w2     = round_key[63:32];
        w3     = round_key[31:0];
        rot_w  = {w3[23:0], w3[31:24]};
        t_word = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])} ^ {rcon, 24'h000000};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Handshake: a transfer occurs on a clk edge where valid and ready are both 1.
    // Valid never depends on ready; outputs stay frozen while a transfer is pending.
    always_comb begin
        state_next      = state;
        key_ready       = 1'b0;
        round_key_valid = 1'b0;
        load_key        = 1'b0;
        advance         = 1'b0;
        finish          = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load_key   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                round_key_valid = 1'b1;
                if (round_key_ready) begin
                    if (round_idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign last = round_key_valid && (round_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            rcon      <= 8'h01;
        end else begin
            state <= state_next;
            if (load_key) begin
                round_key <= key_in;
                round_idx <= '0;
                rcon      <= 8'h01;
            end else if (advance) begin
                round_key <= next_key;
                round_idx <= round_idx + 4'd1;
                rcon      <= xtime(rcon);
            end else if (finish) begin
                round_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key streams, backpressure,
// key during RUN, mid-stream reset, and a NUM_ROUNDS=4 build.
module tb_aes_key_expand;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] key_in;
    logic         key_valid, key_ready;
    logic [127:0] round_key;
    logic         rk_valid, rk_ready;
    logic [3:0]   round_idx;
    logic         last;

    logic [127:0] k4_in;
    logic         k4_valid, k4_ready;
    logic [127:0] rk4;
    logic         r4_valid, r4_ready;
    logic [3:0]   idx4;
    logic         last4;

    aes_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .round_key(round_key), .round_key_valid(rk_valid), .round_key_ready(rk_ready),
        .round_idx(round_idx), .last(last)
    );

    aes_key_expand #(.NUM_ROUNDS(4)) dut4 (
        .clk(clk), .rst(rst), .key_in(k4_in), .key_valid(k4_valid), .key_ready(k4_ready),
        .round_key(rk4), .round_key_valid(r4_valid), .round_key_ready(r4_ready),
        .round_idx(idx4), .last(last4)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h0;

    logic [127:0] fips_rk [0:10];
    logic [127:0] exp_rk  [0:10];
    bit           exp_known [0:10];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("excl_ready_valid", 128'(key_ready && rk_valid), 128'(0));
            chk("last_implies_valid", 128'(last && !rk_valid), 128'(0));
            chk("idx_in_range", 128'(round_idx <= 4'd10), 128'(1));
            chk("excl_ready_valid4", 128'(k4_ready && r4_valid), 128'(0));
            chk("idx4_in_range", 128'(idx4 <= 4'd4), 128'(1));
        end
    end

    task automatic set_fips_table();
        for (int i = 0; i <= 10; i++) begin
            exp_rk[i]    = fips_rk[i];
            exp_known[i] = 1'b1;
        end
    endtask

    task automatic start_key(input logic [127:0] k);
        chk("key_ready_idle", 128'(key_ready), 128'(1));
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // mode 0: ready held 1; mode 1: random ready with a 5-cycle stall at idx 3;
    // mode 2: ready held 1, other key presented from idx 4 and left asserted.
    task automatic drain(input int mode, input logic [127:0] other);
        int e      = 0;
        int cyc    = 0;
        int stalls = 0;
        while (e <= 10 && cyc < 200) begin
            chk("valid_run", 128'(rk_valid), 128'(1));
            chk("key_ready_run", 128'(key_ready), 128'(0));
            chk($sformatf("idx_at_%0d", e), 128'(round_idx), 128'(e));
            if (exp_known[e]) chk($sformatf("key_idx%0d", e), round_key, exp_rk[e]);
            chk($sformatf("last_idx%0d", e), 128'(last), 128'(e == 10));
            case (mode)
                1: begin
                    if (e == 3 && stalls < 5) begin
                        rk_ready = 1'b0;
                        stalls++;
                    end else begin
                        rk_ready = 1'($urandom_range(0, 1));
                    end
                end
                2: begin
                    rk_ready = 1'b1;
                    if (e == 4) begin
                        key_valid = 1'b1;
                        key_in    = other;
                    end
                end
                default: rk_ready = 1'b1;
            endcase
            if (rk_ready) e++;
            cyc++;
            @(negedge clk);
        end
        chk("stream_complete", 128'(e), 128'(11));
        chk("idle_key_ready", 128'(key_ready), 128'(1));
        chk("idle_valid", 128'(rk_valid), 128'(0));
        chk("idle_idx", 128'(round_idx), 128'(0));
        chk("idle_last", 128'(last), 128'(0));
    endtask

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        k4_in     = '0;
        k4_valid  = 1'b0;
        r4_ready  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_round_key", round_key, 128'(0));
        chk("rst_idx", 128'(round_idx), 128'(0));
        chk("rst_last", 128'(last), 128'(0));
        rst      = 1'b0;
        checking = 1'b1;

        // FIPS key with ready held high, then back-to-back with backpressure.
        set_fips_table();
        start_key(FIPS_KEY);
        drain(0, '0);
        start_key(FIPS_KEY);
        drain(1, '0);

        // Key offered during RUN is ignored, then taken in the following idle cycle.
        start_key(FIPS_KEY);
        drain(2, OTHER_KEY);
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i <= 10; i++) exp_known[i] = 1'b0;
        exp_rk[0]     = 128'h0;
        exp_rk[1]     = 128'h62636363626363636263636362636363;
        exp_rk[10]    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        exp_known[0]  = 1'b1;
        exp_known[1]  = 1'b1;
        exp_known[10] = 1'b1;
        drain(0, '0);

        // Mid-stream reset at idx 6.
        set_fips_table();
        start_key(FIPS_KEY);
        rk_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_idx", 128'(round_idx), 128'(6));
        chk("pre_rst_key", round_key, fips_rk[6]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 128'(rk_valid), 128'(0));
        chk("mid_rst_key", round_key, 128'(0));
        chk("mid_rst_key_ready", 128'(key_ready), 128'(1));
        chk("mid_rst_idx", 128'(round_idx), 128'(0));
        @(negedge clk);
        chk("post_rst_quiet", 128'(rk_valid), 128'(0));
        start_key(FIPS_KEY);
        drain(0, '0);

        // NUM_ROUNDS=4 build.
        k4_valid = 1'b1;
        k4_in    = FIPS_KEY;
        @(negedge clk);
        k4_valid = 1'b0;
        r4_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            chk($sformatf("nr4_valid%0d", i), 128'(r4_valid), 128'(1));
            chk($sformatf("nr4_idx%0d", i), 128'(idx4), 128'(i));
            chk($sformatf("nr4_key%0d", i), rk4, fips_rk[i]);
            chk($sformatf("nr4_last%0d", i), 128'(last4), 128'(i == 4));
            @(negedge clk);
        end
        chk("nr4_idle_ready", 128'(k4_ready), 128'(1));
        chk("nr4_idle_valid", 128'(r4_valid), 128'(0));
        chk("nr4_idle_idx", 128'(idx4), 128'(0));

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
